// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer.
// Holds the CP0 ExcCode values, the status-word bit positions, the sequencer
// state encoding, the captured instruction-kind encoding, and a helper that
// maps a trap kind to its ExcCode.
package exc_pkg;

  localparam logic [4:0] C_SYS   = 5'b01000;
  localparam logic [4:0] C_BREAK = 5'b01001;
  localparam logic [4:0] C_TEQ   = 5'b01101;

  localparam int unsigned IE      = 0;
  localparam int unsigned SYSCALL = 1;
  localparam int unsigned BREAK   = 2;
  localparam int unsigned TEQ     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_TRAP  = 3'd2,
    ST_ERET  = 3'd3,
    ST_REDIR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Highest-priority instruction class seen at start; only one is kept.
  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_ERET = 3'd1,
    K_SYS  = 3'd2,
    K_BRK  = 3'd3,
    K_TEQ  = 3'd4
  } kind_t;

  function automatic logic [4:0] cause_code(kind_t k);
    case (k)
      K_SYS:   return C_SYS;
      K_BRK:   return C_BREAK;
      K_TEQ:   return C_TEQ;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/exc_ctrl.sv
// Exception sequencer between the main controller and CP0.
// Captures a trap/eret request on start, checks it against the CP0 status
// word, emits single-cycle exception/eret pulses to CP0, redirects the PC to
// the handler or EPC, and finishes with a one-cycle done pulse.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               one-cycle request (flags/operands valid this cycle)
//   is_syscall/is_break/is_teq/is_eret  decoded instruction class
//   rs_data, rt_data    teq operands
//   pc                  address of current instruction
//   status, epc         CP0 status word and exception return address
//   exception, cause    trap pulse and ExcCode to CP0
//   eret                eret pulse to CP0
//   exc_pc              captured instruction address (to CP0 pc)
//   pc_redirect, redirect_addr  PC load strobe and target
//   busy, done          sequencer active / completion pulse
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  output logic        exception,
  output logic [4:0]  cause,
  output logic        eret,
  output logic [31:0] exc_pc,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        busy,
  output logic        done
);

  state_t state, state_nx;
  kind_t  kind, kind_in;
  logic   teq_hit;

  // Only the low enable bits of status matter here.
  logic status_unused;
  assign status_unused = ^status[31:4];

  function automatic logic trap_enabled(kind_t k, logic [31:0] st, logic hit);
    case (k)
      K_SYS:   return st[IE] & st[SYSCALL];
      K_BRK:   return st[IE] & st[BREAK];
      K_TEQ:   return st[IE] & st[TEQ] & hit;
      default: return 1'b0;
    endcase
  endfunction

  // Priority: eret > syscall > break > teq. Enable checks apply to the
  // winning kind only, so a masked syscall does not fall through to teq.
  always_comb begin
    kind_in = K_NONE;
    if (is_eret)         kind_in = K_ERET;
    else if (is_syscall) kind_in = K_SYS;
    else if (is_break)   kind_in = K_BRK;
    else if (is_teq)     kind_in = K_TEQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind          <= K_NONE;
      teq_hit       <= 1'b0;
      exc_pc        <= '0;
      redirect_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          kind    <= kind_in;
          teq_hit <= (rs_data == rt_data);
          exc_pc  <= pc;
        end
        ST_TRAP: redirect_addr <= HANDLER_ADDR;
        ST_ERET: redirect_addr <= epc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_EVAL;
      ST_EVAL: begin
        if (kind == K_ERET)                         state_nx = ST_ERET;
        else if (trap_enabled(kind, status, teq_hit)) state_nx = ST_TRAP;
        else                                        state_nx = ST_DONE;
      end
      ST_TRAP:  state_nx = ST_REDIR;
      ST_ERET:  state_nx = ST_REDIR;
      ST_REDIR: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    exception   = 1'b0;
    cause       = '0;
    eret        = 1'b0;
    pc_redirect = 1'b0;
    done        = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_TRAP: begin
        exception = 1'b1;
        cause     = cause_code(kind);
      end
      ST_ERET:  eret        = 1'b1;
      ST_REDIR: pc_redirect = 1'b1;
      ST_DONE:  done        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer for the multicycle CPU, sitting directly upstream of the CP0 register file. It takes decoded trap instructions (syscall, break, teq, eret) from the main controller. It checks them against the CP0 status word and drives CP0's `exception`/`cause`/`eret`/`pc` inputs with correct single-cycle pulses. It then redirects the PC to the handler or to EPC, and signals completion back to the main controller via a start/done handshake.

## Interface
- `HANDLER_ADDR`, 32'h0040_0004, trap handler entry address
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request from main controller; instruction flags valid this cycle
- `is_syscall`, `is_break`, `is_teq`, `is_eret`  in  1 each  decoded instruction class
- `rs_data`, `rt_data`  in  32  GPR operands (teq compare)
- `pc`  in  32  address of the current instruction
- `status`  in  32  CP0 status register
- `epc`  in  32  CP0 exception return address
- `exception`  out  1  trap pulse to CP0
- `cause`  out  5  ExcCode to CP0; valid when `exception`=1
- `eret`  out  1  eret pulse to CP0
- `exc_pc`  out  32  captured instruction address, to CP0 `pc`
- `pc_redirect`  out  1  PC load strobe
- `redirect_addr`  out  32  next PC when `pc_redirect`=1
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, EVAL, TRAP, ERET, REDIR, DONE; 3-bit encoding.
- IDLE:
  - On `start`, register the flags, `pc` into `exc_pc`, and `teq_hit` = (`rs_data`==`rt_data`).
  - Go to EVAL.
  - `start` while not IDLE is ignored.
- Kind priority when several flags are set: eret > syscall > break > teq.
- EVAL:
  - eret → ERET.
  - Trap kind with `status[0]`=1 and its enable bit set → TRAP. Enable bits: syscall `status[1]`, break `status[2]`, teq `status[3]`.
  - teq additionally requires `teq_hit`.
  - Otherwise (masked, teq miss, or no flag) → DONE with no CP0 pulse and no redirect.
- TRAP:
  - `exception`=1 and `cause` = 5'b01000 (syscall), 5'b01001 (break) or 5'b01101 (teq).
  - Latch `redirect_addr` ← `HANDLER_ADDR`.
  - Go to REDIR.
- ERET:
  - `eret`=1.
  - Latch `redirect_addr` ← `epc` as sampled this cycle.
  - Go to REDIR.
- REDIR: `pc_redirect`=1 for one cycle → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- All pulse outputs are Moore-decoded from the registered state.
- `cause` is 0 outside TRAP.
- `exc_pc` and `redirect_addr` hold their values until the next capture.

## Timing
- Reset value of every output is 0, including `exc_pc`, `redirect_addr` and `cause`; state goes to IDLE.
- Reset asserted mid-sequence aborts immediately; no pulse may appear in the cycle after reset release.
- Latency from `start` (cycle 0):
  - trap: EVAL c1, `exception` c2, `pc_redirect` c3, `done` c4.
  - eret: identical, with `eret` at c2.
  - no-trap: EVAL c1, `done` c2.
- `exception` and `eret` are exactly one cycle wide and never both high.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `start` in the same cycle as `done` is ignored. The controller must wait for `busy`=0.

## Structure
- Shared package `exc_pkg`:
  - cause codes C_SYS=5'b01000, C_BREAK=5'b01001, C_TEQ=5'b01101
  - status bit indices IE=0, SYSCALL=1, BREAK=2, TEQ=3
  - state encoding constants
- Single module; no sub-module. The enable check is one combinational function inside the module.

## Test plan
- syscall, `status`=32'h1F, `pc`=32'h0040_0100, `start` at c0:
  - `exception` at c2 with `cause`=01000 and `exc_pc`=32'h0040_0100.
  - `pc_redirect` at c3 with addr 32'h0040_0004.
  - `done` at c4.
- teq, `rs_data`=`rt_data`=5 → trap with `cause`=01101. Repeat with `rt_data`=6 → no `exception`, no redirect, `done` at c2.
- break with `status`=32'h1B (break disabled) → `done` at c2, no pulses. Same with `status`=32'h1E (IE=0).
- eret with `epc`=32'h0040_0200 → `eret` at c2 and `pc_redirect` at c3 to 32'h0040_0200. Also assert `is_eret` together with `is_syscall` → eret path wins.
- `rst` asserted at c2 of a trap → all outputs 0 asynchronously. After release: state IDLE, no `pc_redirect`. Extra `start` pulses while `busy` → ignored.
